// File: rtl/iq_chk_pkg.sv
// Shared definitions for the IQ stream checker: state encoding and default parameters.
package iq_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_LOCK_LEN = 8;
    localparam int DEF_LOSS_THR = 4;
    localparam int DEF_CNT_W    = 32;

endpackage

// File: rtl/iq_sync_fifo.sv
// Reference sample FIFO with first-word-fall-through head and up to two pops per cycle.
module iq_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic [1:0]                 pop_n,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push_ok;
    logic [AW:0]      count_nxt;

    // Full is registered, so a same-cycle pop never opens a slot for this cycle's push.
    always_comb begin
        push_ok   = push && !full && !flush;
        count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count_nxt;
            full   <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/iq_stream_checker.sv
// Compares a DUT IQ stream against a queued reference stream, acquiring and tracking
// alignment lock and keeping saturating error statistics.
module iq_stream_checker
    import iq_chk_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int LOSS_THR = DEF_LOSS_THR,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clr,
    input  logic                     ref_valid,
    input  logic signed [DATA_W-1:0] ref_i,
    input  logic signed [DATA_W-1:0] ref_q,
    output logic                     ref_ready,
    input  logic                     dut_valid,
    input  logic signed [DATA_W-1:0] dut_i,
    input  logic signed [DATA_W-1:0] dut_q,
    output logic [1:0]               state,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         cmp_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         slip_cnt,
    output logic                     underflow,
    output logic                     overflow
);

    localparam int RUN_W = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t                    state_r;
    state_t                    state_nxt;
    logic [RUN_W-1:0]          match_run;
    logic [RUN_W-1:0]          miss_run;
    logic [RUN_W-1:0]          match_nxt;
    logic [RUN_W-1:0]          miss_nxt;
    logic [2*DATA_W-1:0]       head;
    logic [FW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [1:0]                pop_n;
    logic signed [DATA_W-1:0]  head_i;
    logic signed [DATA_W-1:0]  head_q;
    logic                      cmp_vld_p0;
    logic                      match_p0;
    logic                      under_p0;
    logic                      over_p0;
    logic                      cmp_inc;
    logic                      err_inc;
    logic                      slip_inc;

    iq_sync_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (!enable),
        .push  (ref_valid && !fifo_full),
        .din   ({ref_i, ref_q}),
        .pop_n (pop_n),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    // Compare stage: DUT sample against the FIFO head.
    always_comb begin
        head_i     = $signed(head[2*DATA_W-1:DATA_W]);
        head_q     = $signed(head[DATA_W-1:0]);
        fifo_empty = (fifo_count == '0);
        cmp_vld_p0 = enable && dut_valid && !fifo_empty && (state_r != ST_IDLE);
        match_p0   = (dut_i == head_i) && (dut_q == head_q);
        under_p0   = dut_valid && fifo_empty;
        over_p0    = ref_valid && fifo_full;
    end

    always_comb begin
        state_nxt = state_r;
        match_nxt = match_run;
        miss_nxt  = miss_run;
        pop_n     = 2'd0;
        cmp_inc   = 1'b0;
        err_inc   = 1'b0;
        slip_inc  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            match_nxt = '0;
            miss_nxt  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (cmp_vld_p0) begin
                        if (match_p0) begin
                            pop_n = 2'd1;
                            if (match_run + RUN_W'(1) >= RUN_W'(LOCK_LEN)) begin
                                state_nxt = ST_LOCKED;
                                match_nxt = '0;
                                miss_nxt  = '0;
                            end else begin
                                match_nxt = match_run + RUN_W'(1);
                            end
                        end else begin
                            // A slip drops the head plus one more entry to shift alignment by one.
                            pop_n     = (fifo_count >= FW'(2)) ? 2'd2 : 2'd1;
                            slip_inc  = 1'b1;
                            match_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (cmp_vld_p0) begin
                        pop_n   = 2'd1;
                        cmp_inc = 1'b1;
                        if (match_p0) begin
                            miss_nxt = '0;
                        end else begin
                            err_inc = 1'b1;
                            if (miss_run + RUN_W'(1) >= RUN_W'(LOSS_THR)) begin
                                state_nxt = ST_SEARCH;
                                match_nxt = '0;
                                miss_nxt  = '0;
                            end else begin
                                miss_nxt = miss_run + RUN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Register stage: state, run counters and statistics; clr beats any same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            cmp_cnt   <= '0;
            err_cnt   <= '0;
            slip_cnt  <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            match_run <= match_nxt;
            miss_run  <= miss_nxt;
            locked    <= (state_nxt == ST_LOCKED);
            err_pulse <= err_inc;
            if (clr) begin
                cmp_cnt   <= '0;
                err_cnt   <= '0;
                slip_cnt  <= '0;
                underflow <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (cmp_inc) begin
                    cmp_cnt <= sat_inc(cmp_cnt);
                end
                if (err_inc) begin
                    err_cnt <= sat_inc(err_cnt);
                end
                if (slip_inc) begin
                    slip_cnt <= sat_inc(slip_cnt);
                end
                if (under_p0) begin
                    underflow <= 1'b1;
                end
                if (over_p0) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign state     = state_r;
    assign ref_ready = !fifo_full;

endmodule

// File: tb/tb_iq_stream_checker.sv
// Directed scoreboard bench for iq_stream_checker (counters narrowed to 4 bits to reach saturation).
module tb_iq_stream_checker;

    localparam int DW = 16;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic                 clr = 1'b0;
    logic                 ref_valid = 1'b0;
    logic signed [DW-1:0] ref_i = '0;
    logic signed [DW-1:0] ref_q = '0;
    logic                 ref_ready;
    logic                 dut_valid = 1'b0;
    logic signed [DW-1:0] dut_i = '0;
    logic signed [DW-1:0] dut_q = '0;
    logic [1:0]           state;
    logic                 locked;
    logic                 err_pulse;
    logic [CW-1:0]        cmp_cnt;
    logic [CW-1:0]        err_cnt;
    logic [CW-1:0]        slip_cnt;
    logic                 underflow;
    logic                 overflow;

    iq_stream_checker #(
        .DATA_W   (DW),
        .DEPTH    (16),
        .LOCK_LEN (8),
        .LOSS_THR (4),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clr       (clr),
        .ref_valid (ref_valid),
        .ref_i     (ref_i),
        .ref_q     (ref_q),
        .ref_ready (ref_ready),
        .dut_valid (dut_valid),
        .dut_i     (dut_i),
        .dut_q     (dut_q),
        .state     (state),
        .locked    (locked),
        .err_pulse (err_pulse),
        .cmp_cnt   (cmp_cnt),
        .err_cnt   (err_cnt),
        .slip_cnt  (slip_cnt),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    localparam int S_STATE = 0, S_LOCKED = 1, S_READY = 2, S_CMP = 3, S_ERR = 4,
                   S_SLIP = 5, S_UNDER = 6, S_OVER = 7, S_PULSE = 8;

    typedef struct {
        int     cyc;
        int     sel;
        longint val;
        string  name;
    } exp_t;

    exp_t   exp_q[$];
    int     pulse_q[$];
    int     cyc = 0;
    int     tests_run = 0;
    int     fails = 0;
    int     ref_idx = 0;
    int     dut_idx = 0;
    int     dut_off = 0;
    exp_t   e;
    longint act;
    int     p;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [DW-1:0] si(input int k);
        return DW'(k * 17 + 5);
    endfunction

    function automatic longint get_act(input int sel);
        case (sel)
            S_STATE:  return longint'(state);
            S_LOCKED: return longint'(locked);
            S_READY:  return longint'(ref_ready);
            S_CMP:    return longint'(cmp_cnt);
            S_ERR:    return longint'(err_cnt);
            S_SLIP:   return longint'(slip_cnt);
            S_UNDER:  return longint'(underflow);
            S_OVER:   return longint'(overflow);
            default:  return longint'(err_pulse);
        endcase
    endfunction

    // Monitor: retires due expectations and matches every err_pulse against the pulse queue.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            act = get_act(e.sel);
            tests_run++;
            if (act !== e.val) begin
                fails++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
        if (err_pulse === 1'b1) begin
            tests_run++;
            if (pulse_q.size() == 0) begin
                fails++;
                $display("FAIL err_pulse: got unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                p = pulse_q.pop_front();
                if (p != cyc) begin
                    fails++;
                    $display("FAIL err_pulse: got pulse at cycle %0d, expected cycle %0d", cyc, p);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input longint v);
        exp_t x;
        x.cyc  = cyc;
        x.sel  = sel;
        x.val  = v;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic expect_pulse();
        pulse_q.push_back(cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rv, input bit dv, input bit bad);
        ref_valid = rv;
        ref_i     = si(ref_idx);
        ref_q     = 16'sh7FFF;
        if (rv) ref_idx++;
        dut_valid = dv;
        dut_i     = si(dut_idx + dut_off);
        dut_q     = bad ? 16'sh8000 : 16'sh7FFF;
        if (dv) dut_idx++;
        step();
        ref_valid = 1'b0;
        dut_valid = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_val({tag, "_state"},  S_STATE,  0);
        expect_val({tag, "_locked"}, S_LOCKED, 0);
        expect_val({tag, "_ready"},  S_READY,  1);
        expect_val({tag, "_cmp"},    S_CMP,    0);
        expect_val({tag, "_err"},    S_ERR,    0);
        expect_val({tag, "_slip"},   S_SLIP,   0);
        expect_val({tag, "_under"},  S_UNDER,  0);
        expect_val({tag, "_over"},   S_OVER,   0);
        expect_val({tag, "_pulse"},  S_PULSE,  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values
        step();
        step();
        reset = 1'b0;
        expect_reset_state("rst");

        // Identical streams, DUT three samples behind
        enable = 1'b1;
        repeat (3) drive(1, 0, 0);
        expect_val("srch_state", S_STATE, 1);
        repeat (7) drive(1, 1, 0);
        expect_val("pre_lock_locked", S_LOCKED, 0);
        drive(1, 1, 0);
        expect_val("lock_locked", S_LOCKED, 1);
        expect_val("lock_state", S_STATE, 2);
        expect_val("lock_cmp", S_CMP, 0);
        repeat (4) drive(1, 1, 0);
        expect_val("aligned_cmp", S_CMP, 4);
        expect_val("aligned_err", S_ERR, 0);

        // Single corrupted Q sample while locked
        drive(1, 1, 1);
        expect_pulse();
        expect_val("corrupt_err", S_ERR, 1);
        expect_val("corrupt_cmp", S_CMP, 5);
        expect_val("corrupt_locked", S_LOCKED, 1);
        drive(1, 1, 0);
        expect_val("after_corrupt_pulse", S_PULSE, 0);
        expect_val("after_corrupt_locked", S_LOCKED, 1);

        // clr wins over a same-cycle increment
        clr = 1'b1;
        drive(1, 1, 0);
        clr = 1'b0;
        expect_val("clr_cmp", S_CMP, 0);
        expect_val("clr_err", S_ERR, 0);

        // Three bad then one good keeps lock; four bad drops it
        repeat (3) begin
            drive(1, 1, 1);
            expect_pulse();
        end
        drive(1, 1, 0);
        expect_val("3bad_state", S_STATE, 2);
        expect_val("3bad_err", S_ERR, 3);
        expect_val("3bad_cmp", S_CMP, 4);
        repeat (3) begin
            drive(1, 1, 1);
            expect_pulse();
        end
        expect_val("3of4_state", S_STATE, 2);
        drive(1, 1, 1);
        expect_pulse();
        expect_val("4bad_state", S_STATE, 1);
        expect_val("4bad_locked", S_LOCKED, 0);
        expect_val("4bad_err", S_ERR, 7);
        expect_val("4bad_cmp", S_CMP, 8);

        // Disable holds counters
        enable = 1'b0;
        drive(0, 0, 0);
        expect_val("dis_state", S_STATE, 0);
        expect_val("dis_err_hold", S_ERR, 7);
        expect_val("dis_cmp_hold", S_CMP, 8);
        clr = 1'b1;
        drive(0, 0, 0);
        clr = 1'b0;
        expect_val("dis_clr_err", S_ERR, 0);

        // DUT stream two samples ahead: two slips, then lock
        ref_idx = 0;
        dut_idx = 0;
        dut_off = 2;
        enable  = 1'b1;
        repeat (3) drive(1, 0, 0);
        drive(1, 1, 0);
        expect_val("slip1", S_SLIP, 1);
        drive(1, 1, 0);
        expect_val("slip2", S_SLIP, 2);
        expect_val("slip2_state", S_STATE, 1);
        repeat (7) drive(1, 1, 0);
        expect_val("slip_pre_lock", S_LOCKED, 0);
        drive(1, 1, 0);
        expect_val("slip_lock", S_LOCKED, 1);
        expect_val("slip_final", S_SLIP, 2);
        expect_val("slip_err", S_ERR, 0);

        // Mid-stream reset with five entries queued
        repeat (4) drive(1, 0, 0);
        expect_val("queued_locked", S_LOCKED, 1);
        reset = 1'b1;
        clr   = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        clr   = 1'b0;
        expect_reset_state("midrst");
        drive(0, 1, 0);
        expect_val("midrst_empty_under", S_UNDER, 1);
        expect_val("midrst_search", S_STATE, 1);

        // Fill to overflow, push-while-full with pop, wrap-around drain
        reset = 1'b1;
        drive(0, 0, 0);
        reset   = 1'b0;
        ref_idx = 0;
        dut_idx = 0;
        dut_off = 0;
        repeat (15) drive(1, 0, 0);
        expect_val("fill15_ready", S_READY, 1);
        drive(1, 0, 0);
        expect_val("fill16_ready", S_READY, 0);
        expect_val("fill16_over", S_OVER, 0);
        drive(1, 0, 0);
        expect_val("fill17_over", S_OVER, 1);
        expect_val("fill17_ready", S_READY, 0);
        drive(1, 1, 0);
        expect_val("full_pop_ready", S_READY, 1);
        drive(1, 0, 0);
        expect_val("refill_ready", S_READY, 0);
        repeat (7) drive(0, 1, 0);
        expect_val("drain_lock", S_LOCKED, 1);
        expect_val("drain_lock_cmp", S_CMP, 0);
        repeat (8) drive(0, 1, 0);
        expect_val("drain_cmp", S_CMP, 8);
        expect_val("drain_err", S_ERR, 0);
        drive(0, 1, 0);
        expect_pulse();
        expect_val("wrap_entry_err", S_ERR, 1);
        expect_val("wrap_entry_cmp", S_CMP, 9);
        expect_val("empty_under_pre", S_UNDER, 0);

        // Same-cycle push into empty FIFO: underflow, no compare
        drive(1, 1, 0);
        expect_val("push_empty_under", S_UNDER, 1);
        expect_val("push_empty_cmp", S_CMP, 9);
        expect_val("push_empty_state", S_STATE, 2);

        // Counter saturation at all-ones
        dut_idx = ref_idx - 1;
        repeat (6) drive(1, 1, 0);
        expect_val("sat_reach", S_CMP, 15);
        repeat (6) drive(1, 1, 0);
        expect_val("sat_hold", S_CMP, 15);
        expect_val("sat_err", S_ERR, 1);
        expect_val("sat_locked", S_LOCKED, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            tests_run++;
            fails++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        tests_run++;
        if (pulse_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulse: got %0d pulses outstanding, expected 0", pulse_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/iq_stream_checker.md
IQ_STREAM_CHECKER -- requirements
Module: iq_stream_checker

Interface
REQ-001 The block SHALL have parameters:
- DATA_W, default 16: I/Q sample width, two's complement.
- DEPTH, default 16: reference FIFO depth, power of two, at least 4.
- LOCK_LEN, default 8: consecutive matches needed to lock.
- LOSS_THR, default 4: consecutive locked mismatches needed to drop lock.
- CNT_W, default 32: statistics counter width.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  checker run; 0 forces IDLE.
- clr  in  1  synchronous clear of statistics counters and sticky flags.
- ref_valid  in  1  reference sample present.
- ref_i  in  DATA_W  reference I.
- ref_q  in  DATA_W  reference Q.
- ref_ready  out  1  FIFO can accept a sample.
- dut_valid  in  1  DUT sample present; no backpressure.
- dut_i  in  DATA_W  DUT I.
- dut_q  in  DATA_W  DUT Q.
- state  out  2  0 = IDLE, 1 = SEARCH, 2 = LOCKED.
- locked  out  1  high when state is LOCKED.
- err_pulse  out  1  one-cycle pulse for each mismatch while LOCKED.
- cmp_cnt  out  CNT_W  comparisons made while LOCKED.
- err_cnt  out  CNT_W  mismatches made while LOCKED.
- slip_cnt  out  CNT_W  alignment slips made while in SEARCH.
- underflow  out  1  sticky flag.
- overflow  out  1  sticky flag.

Function
REQ-003 ref_ready SHALL equal not-full and SHALL NOT depend on same-cycle pops; a push occurs when ref_valid and ref_ready are both high.
REQ-004 When ref_valid is high while the FIFO is full, the sample SHALL be dropped and overflow SHALL be set.
REQ-005 A compare event SHALL occur when dut_valid is high, the FIFO is non-empty and state is not IDLE: the DUT sample is checked against the FIFO head for equality of both I and Q, and the head is popped.
REQ-006 When dut_valid is high and the FIFO is empty, including a same-cycle push into an empty FIFO, there SHALL be no compare and underflow SHALL be set.
REQ-007 In SEARCH, a mismatch SHALL pop one additional entry if one exists (a slip, which advances reference alignment by one), increment slip_cnt and reset the match run to 0.
REQ-008 In SEARCH, a match SHALL increment the match run; reaching LOCK_LEN SHALL move state to LOCKED on that edge.
REQ-009 In LOCKED, each compare SHALL increment cmp_cnt; each mismatch SHALL increment err_cnt and assert err_pulse on the following cycle.
REQ-010 In LOCKED, LOSS_THR consecutive mismatches SHALL move state to SEARCH and clear the run counters; any match SHALL reset the miss run.
REQ-011 Transitions:
- IDLE to SEARCH when enable is 1.
- Any state to IDLE when enable is 0; the FIFO is flushed and the statistics counters hold their values.
REQ-012 All counters SHALL saturate at all-ones and never wrap.
REQ-013 clr SHALL zero cmp_cnt, err_cnt, slip_cnt, underflow and overflow; a same-cycle increment or set SHALL be lost, because clr wins.
REQ-014 All outputs SHALL be registered, and state/flag/counter updates SHALL be visible one cycle after the triggering input cycle.
REQ-015 The FIFO SHALL support a simultaneous push and pop, including when full (the pop frees space on the next cycle only) and with pointer wrap-around at DEPTH.

Reset
REQ-016 With reset high at a rising edge, the block SHALL take these values:
- state = IDLE.
- FIFO empty; ref_ready = 1.
- All counters, run counters and sticky flags = 0.
- locked = 0; err_pulse = 0.
REQ-017 A reset mid-stream SHALL discard FIFO contents and lock state; reset SHALL take priority over enable and clr.

Structure
REQ-018 The state encoding and the default parameter values SHALL live in the shared package iq_chk_pkg.
REQ-019 The reference FIFO SHALL be the sub-module iq_sync_fifo (parameters DATA_W×2 and DEPTH, first-word-fall-through head).

Verification
REQ-020 Identical streams, one sample per cycle, with DUT delayed 3 cycles -> locked = 1 after 8 compares, err_cnt = 0.
REQ-021 DUT stream offset by 2 samples (DUT sample n = ref sample n+2) -> slip_cnt = 2, then lock after 8 matches.
REQ-022 When LOCKED, corrupt one Q sample (0x7FFF flipped to 0x8000) -> one err_pulse, err_cnt = 1, locked stays 1.
REQ-023 When LOCKED, 4 consecutive bad samples -> state = SEARCH; 3 bad then 1 good -> stays LOCKED with err_cnt = 3.
REQ-024 Push 17 samples into DEPTH = 16 with no dut_valid -> ref_ready = 0 after 16 pushes, overflow = 1; a dut_valid on an empty FIFO -> underflow = 1.
REQ-025 Pulse reset while LOCKED with 5 entries queued -> on the next cycle state = IDLE, FIFO empty, all counters 0.
